// File: rtl/instr_word_encoder.sv
// Purpose : assembles RV32I instruction words from decoded fields and streams them to instruction memory.
// Latency : handshake at cycle N, mem_we at N+2; at least 3 cycles per word (IDLE, ENC, WRITE).
// Backpr. : in_ready is low outside IDLE; WRITE holds mem_we/mem_addr/mem_wdata stable until mem_ack.
//
// Ports: clk/reset (sync, active-low), start (clear counters/flags, leave DONE),
//        in_* field set with valid/ready, mem_* write port with ack,
//        word_count/done/err/ovf status.
module instr_word_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_last,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [15:0] word_count,
  output logic        done,
  output logic        err,
  output logic        ovf
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

  typedef enum logic [1:0] {IDLE, ENC, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [6:0]  op_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [31:0] imm_q;
  logic        last_q;
  logic        rdy_q;

  logic [31:0] word;
  logic        legal;
  logic        fits12, fits13, fits21;
  logic        accept;

  assign in_ready = rdy_q;
  assign accept   = in_valid && rdy_q;

  // A value is sign-representable in N bits when bits [31:N-1] are all equal.
  always_comb begin
    fits12 = (&imm_q[31:11]) || (~|imm_q[31:11]);
    fits13 = (&imm_q[31:12]) || (~|imm_q[31:12]);
    fits21 = (&imm_q[31:20]) || (~|imm_q[31:20]);
    word   = '0;
    legal  = 1'b0;
    case (op_q)
      OP_R: begin
        word  = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
        legal = (f7_q == 7'b0000000) || (f7_q == 7'b0100000);
      end
      OP_I: begin
        word  = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
        legal = fits12;
      end
      OP_LW: begin
        word  = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
        legal = fits12 && (f3_q == 3'b010);
      end
      OP_JALR: begin
        word  = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
        legal = fits12 && (f3_q == 3'b000);
      end
      OP_S: begin
        word  = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
        legal = fits12 && (f3_q == 3'b010);
      end
      OP_B: begin
        word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], op_q};
        // beq/bne/blt/bge are exactly the funct3 codes with bit 1 clear
        legal = fits13 && !imm_q[0] && !f3_q[1];
      end
      OP_LUI, OP_AUIPC: begin
        word  = {imm_q[31:12], rd_q, op_q};
        legal = (imm_q[11:0] == 12'h000);
      end
      OP_JAL: begin
        word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
        legal = fits21 && !imm_q[0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ENC;
      ENC:     state_nxt = legal ? WRITE : IDLE;
      WRITE:   if (mem_ack) state_nxt = last_q ? DONE : IDLE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    // start never tears a write; in IDLE an accepted field set still proceeds
    if (start && (state == ENC || state == DONE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdy_q      <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      word_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      op_q       <= '0;
      f3_q       <= '0;
      f7_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      rdy_q <= (state_nxt == IDLE);
      if (accept) begin
        op_q   <= in_opcode;
        f3_q   <= in_funct3;
        f7_q   <= in_funct7;
        rd_q   <= in_rd;
        rs1_q  <= in_rs1;
        rs2_q  <= in_rs2;
        imm_q  <= in_imm;
        last_q <= in_last;
      end
      if (start && state != WRITE) begin
        mem_addr   <= BASE_ADDR;
        word_count <= '0;
        done       <= 1'b0;
        err        <= 1'b0;
        ovf        <= 1'b0;
      end else begin
        case (state)
          ENC: begin
            if (legal) begin
              mem_wdata <= word;
              mem_we    <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          WRITE: begin
            if (mem_ack) begin
              mem_we     <= 1'b0;
              word_count <= word_count + 16'd1;
              if (last_q) done <= 1'b1;
              if (mem_addr == LAST_ADDR) begin
                mem_addr <= BASE_ADDR;
                ovf      <= 1'b1;
              end else begin
                mem_addr <= mem_addr + 32'd4;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_word_encoder.sv
module tb_instr_word_encoder;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LW = 7'h03, OP_S = 7'h23;
  localparam logic [6:0] OP_B = 7'h63, OP_JAL = 7'h6F, OP_LUI = 7'h37;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, in_last, mem_ack;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, mem_we, done, err, ovf;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_count;

  logic        d4_in_ready, d4_mem_we, d4_done, d4_err, d4_ovf;
  logic [31:0] d4_mem_addr, d4_mem_wdata;
  logic [15:0] d4_word_count;

  instr_word_encoder #(.BASE_ADDR(BASE), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .word_count(word_count), .done(done), .err(err), .ovf(ovf)
  );

  // Small-window copy driven in lockstep to exercise address wrap.
  instr_word_encoder #(.BASE_ADDR(BASE), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(d4_mem_we), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata), .mem_ack(mem_ack),
    .word_count(d4_word_count), .done(d4_done), .err(d4_err), .ovf(d4_ovf)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor: every accepted write is compared against the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we && mem_ack) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic last, input logic legal,
                      input logic [31:0] exp_word, input logic [31:0] exp_addr);
    int t;
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL handshake_timeout: in_ready still %b after %0d cycles, required 1", in_ready, t);
    end
    if (legal) exp_q.push_back('{addr: exp_addr, data: exp_word});
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_rdy();
    int t;
    t = 0;
    while (!(in_ready || done) && t < 50) begin
      step();
      t++;
    end
    if (!(in_ready || done)) begin
      n_chk++;
      $display("FAIL idle_timeout: in_ready %b done %b after %0d cycles, required one high", in_ready, done, t);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [31:0] wrap_words [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ack = 1'b1; in_last = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    wrap_words[0] = 32'h0010_0093;
    wrap_words[1] = 32'h0020_0113;
    wrap_words[2] = 32'h0030_0193;
    wrap_words[3] = 32'h0040_0213;
    wrap_words[4] = 32'h0050_0293;
    step(); step();

    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", word_count, 0);
    chk("rst_flags", {done, err, ovf}, 0);
    chk("rst_ready", in_ready, 0);
    reset = 1'b1;
    step();
    chk("ready_after_rst", in_ready, 1);

    // add x3,x1,x2 with latency check
    send(OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h0020_81B3, BASE);
    chk("lat_n1_we", mem_we, 0);
    step();
    chk("lat_n2_we", mem_we, 1);
    wait_rdy();
    chk("count_1", word_count, 1);

    // program sequence ending with in_last
    send(OP_I,   3'd0, 7'd0, 5'd5,  5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFF0_0293, BASE + 32'h04);
    send(OP_S,   3'd2, 7'd0, 5'd0,  5'd1, 5'd2, 32'd8,         1'b0, 1'b1, 32'h0020_A423, BASE + 32'h08);
    send(OP_B,   3'd0, 7'd0, 5'd0,  5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFE20_8EE3, BASE + 32'h0C);
    send(OP_JAL, 3'd0, 7'd0, 5'd1,  5'd0, 5'd0, 32'd8,         1'b0, 1'b1, 32'h0080_00EF, BASE + 32'h10);
    send(OP_LUI, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 1'b1, 32'h1234_5537, BASE + 32'h14);
    wait_rdy();
    step(); step();
    chk("seq_done", done, 1);
    chk("seq_ready", in_ready, 0);
    chk("seq_count", word_count, 6);
    chk("seq_addr", mem_addr, BASE + 32'h18);

    // illegal field sets leave address and count alone
    pulse_start();
    chk("start_done", done, 0);
    chk("start_addr", mem_addr, BASE);
    send(OP_B, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rdy();
    chk("bad_f3_err", err, 1);
    chk("bad_f3_addr", mem_addr, BASE);
    chk("bad_f3_count", word_count, 0);
    send(OP_B, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1, 1'b0, 32'd0, 32'd0);
    wait_rdy();
    chk("odd_imm_ready", in_ready, 1);
    chk("odd_imm_done", done, 0);
    chk("odd_imm_addr", mem_addr, BASE);
    send(OP_LW, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rdy();
    send(OP_I, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rdy();
    chk("bad_count", word_count, 0);
    send(OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h0020_81B3, BASE);
    wait_rdy();
    chk("post_err_count", word_count, 1);
    chk("err_sticky", err, 1);

    // memory stall: outputs hold, no new field set accepted
    mem_ack = 1'b0;
    send(OP_I, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFF0_0293, BASE + 32'h04);
    step();
    in_valid = 1'b1; in_opcode = OP_R; in_rd = 5'd7; in_imm = 32'd0; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_we", mem_we, 1);
      chk("stall_addr", mem_addr, BASE + 32'h04);
      chk("stall_data", mem_wdata, 32'hFFF0_0293);
      chk("stall_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    mem_ack = 1'b1;
    step();
    chk("stall_count", word_count, 2);

    // address wrap in the 4-word window
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      send(OP_I, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1), 1'b0, 1'b1,
           wrap_words[i], BASE + 32'(4 * i));
      if (i == 4) begin
        step();
        chk("wrap_we", d4_mem_we, 1);
        chk("wrap_addr", d4_mem_addr, BASE);
        chk("wrap_data", d4_mem_wdata, 32'h0050_0293);
      end
      wait_rdy();
      if (i == 2) chk("wrap_ovf_pre", d4_ovf, 0);
      if (i == 3) begin
        chk("wrap_ovf_set", d4_ovf, 1);
        chk("wrap_addr_base", d4_mem_addr, BASE);
        chk("nowrap_ovf", ovf, 0);
      end
    end
    chk("wrap_count", d4_word_count, 5);
    chk("nowrap_addr", mem_addr, BASE + 32'h14);
    pulse_start();
    chk("clr_ovf", d4_ovf, 0);
    chk("clr_count", d4_word_count, 0);
    chk("clr_addr", d4_mem_addr, BASE);

    // reset in the middle of a stalled write
    send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rdy();
    chk("bad_op_err", err, 1);
    mem_ack = 1'b0;
    send(OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    chk("mid_write_we", mem_we, 1);
    reset = 1'b0;
    step();
    chk("rst2_we", mem_we, 0);
    chk("rst2_addr", mem_addr, BASE);
    chk("rst2_wdata", mem_wdata, 0);
    chk("rst2_count", word_count, 0);
    chk("rst2_flags", {done, err, ovf}, 0);
    chk("rst2_ready", in_ready, 0);
    reset = 1'b1;
    mem_ack = 1'b1;
    step();
    chk("rst2_ready_after", in_ready, 1);
    send(OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h0020_81B3, BASE);
    wait_rdy();
    chk("recover_count", word_count, 1);

    step(); step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_word_encoder.md
Name: instr_word_encoder

Overview:
- Producing end of the instruction path. Assembles RV32I instruction words from decoded fields (opcode, funct3, funct7, rd, rs1, rs2, imm) and streams them into instruction memory through a write port.
- Covers exactly the opcode set the single-cycle control unit decodes: R, I-arith, lw, sw, B (beq/bne/blt/bge), jalr, jal, lui, auipc.
- Used by the program-load path and by the self-checking benches to build programs in hardware.

Parameters:
- BASE_ADDR, 32'h0040_0000, byte address of the first written word.
- DEPTH, 64, number of words in the target memory window; the address wraps after DEPTH words.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle pulse: clear address, done, err and ovf; leave DONE.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept a field set.
- in_opcode  in  7  instruction opcode.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R-type only).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed byte-offset or immediate value.
- in_last  in  1  marks the final word of the program.
- mem_we  out  1  write request to instruction memory.
- mem_addr  out  32  byte address of the write.
- mem_wdata  out  32  encoded instruction word.
- mem_ack  in  1  memory accepted the write this cycle.
- word_count  out  16  words written since the last start or reset.
- done  out  1  last word written.
- err  out  1  sticky: an illegal field set was rejected.
- ovf  out  1  sticky: the address wrapped.

Behaviour:
- Reset (reset=0 at a clk edge, any state, including mid-WRITE):
  - State goes to IDLE.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, done=0, err=0, ovf=0.
  - in_ready becomes 1 on the cycle after reset deasserts.
- States: IDLE, ENC, WRITE, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready, latch all in_* fields and go to ENC.
- ENC (1 cycle, in_ready=0): compute the word and the legality check.
  - Illegal: set err, do not write, leave address unchanged, return to IDLE (even if in_last).
  - Legal: load mem_wdata, go to WRITE.
- WRITE:
  - mem_we=1; mem_addr and mem_wdata held stable until mem_ack.
  - On the mem_ack cycle: word_count+1 and mem_addr+4.
  - If mem_addr was BASE_ADDR+4*(DEPTH-1), it wraps to BASE_ADDR and ovf is set.
  - Next state is DONE if the latched last=1, else IDLE.
  - mem_we drops on the cycle after the ack.
- Latency: handshake at cycle N, mem_we=1 at N+2; minimum 3 cycles per word with mem_ack tied high.
- DONE:
  - done=1, in_ready=0.
  - Stays until start or reset.
- start: honoured in any state except WRITE, where it is ignored so no write is torn. It returns the block to IDLE with counters and flags cleared. If start and reset are both active, reset wins.
- Encoding by opcode (unlisted bits are zero):
  - R 0110011: funct7|rs2|rs1|funct3|rd|op.
  - I 0010011, lw 0000011, jalr 1100111: imm[11:0]|rs1|funct3|rd|op.
  - S 0100011: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B 1100011: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U 0110111/0010111: imm[31:12]|rd|op.
  - J 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Legality (any failure is illegal):
  - Opcode not in the list above.
  - B with funct3 not in {000,001,100,101}.
  - lw funct3≠010; sw funct3≠010; jalr funct3≠000.
  - R funct7 not 0000000 or 0100000.
  - I/S imm not sign-representable in 12 bits.
  - B imm not sign-representable in 13 bits, or imm[0]=1.
  - J imm not sign-representable in 21 bits, or imm[0]=1.
  - U imm[11:0]≠0.
- err and ovf never clear except on reset or start. word_count wraps modulo 2^16.

Test Plan:
- add x3,x1,x2 (op 33h, f3 0, f7 0, rd3 rs1 1 rs2 2), mem_ack=1 -> mem_wdata=002081B3h at 00400000h, mem_we high 2 cycles after handshake, word_count=1.
- Sequence: addi x5,x0,-1 -> FFF00293h; sw x2,8(x1) -> 0020A423h; beq x1,x2,-4 -> FE208EE3h; jal x1,8 -> 008000EFh; lui x10,12345000h with in_last=1 -> 12345537h.
  - Required: addresses 00400004h..00400014h, done=1, in_ready=0 afterwards.
- Branch with f3=010, then beq imm=3 -> err=1 on both, no mem_we, mem_addr unchanged; the next legal word is written at the original address.
- mem_ack held low 5 cycles during WRITE -> mem_we, mem_addr and mem_wdata stable all 5 cycles; in_valid during the stall is not accepted.
- DEPTH=4, 5 legal words -> 5th word written at BASE_ADDR, ovf=1; start pulse -> ovf=0, word_count=0, mem_addr=BASE_ADDR.
- reset low during WRITE with mem_ack=0 -> next cycle mem_we=0, state IDLE, all outputs at reset values.
